// File: rtl/ov7670_config_ctrl_if.sv
// ov7670_config_ctrl_if
//   Write-request handshake between the OV7670 configuration sequencer and the
//   SCCB write master.
//   req   : one-cycle write request (sequencer -> master)
//   addr  : 8-bit camera register address, valid while req=1
//   data  : 8-bit register value, valid while req=1
//   ready : master idle; drops after accepting a request, returns when done
interface ov7670_config_ctrl_if;
  logic       req;
  logic [7:0] addr;
  logic [7:0] data;
  logic       ready;

  modport master (output req, output addr, output data, input ready);
  modport slave  (input req, input addr, input data, output ready);
endinterface

// File: rtl/ov7670_config_ctrl.sv
// ov7670_config_ctrl
//   Writes the OV7670 register table through the SCCB write master, waits out
//   the soft reset and a number of settle frames, then enables pixel capture.
//   The table is re-run on a start pulse or whenever rgbmode changes, so the
//   camera output format always tracks rgbmode.
// Ports
//   clk        : system clock
//   rst        : synchronous, active-high reset
//   start      : one-cycle pulse, re-run the full configuration
//   rgbmode    : 1 = RGB444 table variant, 0 = YUV422 variant
//   vsync      : camera vsync (asynchronous, synchronised here)
//   sccb       : master side of the SCCB write handshake
//   busy       : configuration or settle in progress
//   cfg_done   : table written and settle elapsed
//   capture_en : enables the capture write path
//   err        : sticky ack-timeout flag, cleared by rst or a restart
module ov7670_config_ctrl #(
  parameter int unsigned c_rst_wait      = 1_000_000,
  parameter int unsigned c_ack_timeout   = 1024,
  parameter int unsigned c_settle_frames = 2,
  parameter int unsigned c_tbl_len       = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        rgbmode,
  input  logic                        vsync,
  ov7670_config_ctrl_if.master        sccb,
  output logic                        busy,
  output logic                        cfg_done,
  output logic                        capture_en,
  output logic                        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ACK, S_XFER, S_DLY, S_SETTLE, S_DONE
  } state_t;

  // One shared counter serves the reset delay, the ack timeout and the
  // settle-frame count; it is cleared on every state entry.
  localparam int unsigned c_cnt_max0 = (c_rst_wait > c_ack_timeout) ? c_rst_wait : c_ack_timeout;
  localparam int unsigned c_cnt_max  = (c_cnt_max0 > c_settle_frames) ? c_cnt_max0 : c_settle_frames;
  localparam int unsigned c_cnt_w    = $clog2(c_cnt_max + 1);
  typedef logic [c_cnt_w-1:0] cnt_t;

  state_t     state, state_nxt;
  logic [2:0] idx;
  logic       rgb_lat;
  logic       restart_pend;
  cnt_t       cnt;
  logic [2:0] vs_sync;
  logic       vs_rise;
  logic       trig, restart_now, ack_tmo, issue;
  logic       done_nxt;
  logic [7:0] tbl_addr, tbl_data;

  assign vs_rise = vs_sync[1] & ~vs_sync[2];
  assign trig    = start | (rgb_lat != rgbmode);

  // Register table; index 0 is the COM7 soft reset.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    tbl_addr = 8'h00;
    tbl_data = 8'h00;
    case (idx)
      3'd0: begin tbl_addr = 8'h12; tbl_data = 8'h80; end
      3'd1: begin tbl_addr = 8'h12; tbl_data = rgb_lat ? 8'h04 : 8'h00; end
      3'd2: begin tbl_addr = 8'h8C; tbl_data = rgb_lat ? 8'h02 : 8'h00; end
      3'd3: begin tbl_addr = 8'h40; tbl_data = rgb_lat ? 8'hD0 : 8'hC0; end
      3'd4: begin tbl_addr = 8'h0C; tbl_data = 8'h04; end
      3'd5: begin tbl_addr = 8'h3E; tbl_data = 8'h1A; end
      3'd6: begin tbl_addr = 8'h72; tbl_data = 8'h22; end
      default: begin tbl_addr = 8'h73; tbl_data = 8'hF2; end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. A restart in a transaction-free state takes effect at
  // once; inside ACK/XFER it is deferred until the master returns to ready.
  always_comb begin
    state_nxt   = state;
    restart_now = 1'b0;
    ack_tmo     = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (trig || restart_pend) restart_now = 1'b1;
        else if (sccb.ready)      state_nxt   = S_ACK;
      end
      S_ACK: begin
        if (!sccb.ready) state_nxt = S_XFER;
        else if (cnt == cnt_t'(c_ack_timeout - 1)) begin
          ack_tmo   = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_XFER: begin
        if (sccb.ready) begin
          if (trig || restart_pend)               restart_now = 1'b1;
          else if (idx == 3'd0)                   state_nxt   = S_DLY;
          else if (idx == 3'(c_tbl_len - 1))      state_nxt   = S_SETTLE;
          else                                    state_nxt   = S_REQ;
        end
      end
      S_DLY: begin
        if (trig || restart_pend)                     restart_now = 1'b1;
        else if (cnt == cnt_t'(c_rst_wait - 1))       state_nxt   = S_REQ;
      end
      S_SETTLE: begin
        if (trig || restart_pend) restart_now = 1'b1;
        else if (vs_rise && cnt == cnt_t'(c_settle_frames - 1)) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (trig || restart_pend) restart_now = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (restart_now) state_nxt = S_REQ;
  end

  // Output decode: busy is direct; the rest are next values for registered outputs.
  always_comb begin
    busy     = !(state inside {S_IDLE, S_DONE});
    issue    = (state == S_REQ) && (state_nxt == S_ACK);
    done_nxt = (state == S_DONE) && !restart_now;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sccb.req     <= 1'b0;
      sccb.addr    <= 8'h00;
      sccb.data    <= 8'h00;
      cfg_done     <= 1'b0;
      capture_en   <= 1'b0;
      err          <= 1'b0;
      idx          <= 3'd0;
      rgb_lat      <= 1'b0;
      restart_pend <= 1'b0;
      cnt          <= '0;
      vs_sync      <= 3'b000;
    end else begin
      vs_sync    <= {vs_sync[1:0], vsync};
      sccb.req   <= issue;
      cfg_done   <= done_nxt;
      capture_en <= done_nxt;
      if (issue) begin
        sccb.addr <= tbl_addr;
        sccb.data <= tbl_data;
      end

      // Counter saturates instead of wrapping; SETTLE counts vsync edges only.
      if (state_nxt != state || restart_now)  cnt <= '0;
      else if (state == S_SETTLE) begin
        if (vs_rise) cnt <= cnt + cnt_t'(1);
      end
      else if (cnt != cnt_t'(c_cnt_max))      cnt <= cnt + cnt_t'(1);

      if (state == S_IDLE || restart_now) begin
        idx     <= 3'd0;
        rgb_lat <= rgbmode;
        err     <= 1'b0;
      end else begin
        if (ack_tmo) err <= 1'b1;
        if (state == S_XFER && state_nxt == S_REQ) idx <= idx + 3'd1;
        else if (state == S_DLY && state_nxt == S_REQ) idx <= 3'd1;
      end

      if (restart_now) restart_pend <= 1'b0;
      else if ((state == S_ACK || state == S_XFER) && trig) restart_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ov7670_config_ctrl.sv
// tb_ov7670_config_ctrl
//   Scoreboard bench: expected SCCB writes are queued as stimulus is applied
//   and compared against each request pulse the controller issues. A small
//   SCCB master model answers requests and can be told to ignore some.
module tb_ov7670_config_ctrl;
  localparam int unsigned c_rst_wait      = 10;
  localparam int unsigned c_ack_timeout   = 8;
  localparam int unsigned c_settle_frames = 2;

  logic clk = 1'b0;
  logic rst, start, rgbmode, vsync;
  logic busy, cfg_done, capture_en, err;

  ov7670_config_ctrl_if sccb ();

  ov7670_config_ctrl #(
    .c_rst_wait     (c_rst_wait),
    .c_ack_timeout  (c_ack_timeout),
    .c_settle_frames(c_settle_frames),
    .c_tbl_len      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rgbmode   (rgbmode),
    .vsync     (vsync),
    .sccb      (sccb),
    .busy      (busy),
    .cfg_done  (cfg_done),
    .capture_en(capture_en),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected table entry {addr, data}.
  function automatic logic [15:0] ent(input int i, input logic rgb);
    case (i)
      0:       ent = 16'h1280;
      1:       ent = rgb ? 16'h1204 : 16'h1200;
      2:       ent = rgb ? 16'h8C02 : 16'h8C00;
      3:       ent = rgb ? 16'h40D0 : 16'h40C0;
      4:       ent = 16'h0C04;
      5:       ent = 16'h3E1A;
      6:       ent = 16'h7222;
      default: ent = 16'h73F2;
    endcase
  endfunction

  logic [15:0] exp_q[$];
  int          req_cyc[$];
  int          n_req = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // SCCB master model: drops ready the cycle after a request, returns it
  // 20 cycles later. Requests are ignored while ignored < ignore_total.
  int ignore_total = 0;
  int ignored = 0;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      sccb.ready <= 1'b1;
      busy_cnt   <= 0;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) sccb.ready <= 1'b1;
    end else if (sccb.req) begin
      if (ignored < ignore_total) ignored <= ignored + 1;
      else begin
        sccb.ready <= 1'b0;
        busy_cnt   <= 20;
      end
    end
  end

  // Request monitor / scoreboard.
  always @(negedge clk) begin : mon
    logic [15:0] e;
    if (!rst && sccb.req) begin
      n_req++;
      req_cyc.push_back(cyc);
      check("req_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sccb_addr", 32'(sccb.addr), 32'(e[15:8]));
        check("sccb_data", 32'(sccb.data), 32'(e[7:0]));
      end
    end
  end

  // capture_en must never coincide with busy.
  always @(negedge clk) begin
    if (!rst && capture_en) check("cap_not_busy", 32'(busy), 32'd0);
  end

  task automatic push_run(input logic rgb, input int first, input int last);
    for (int i = first; i <= last; i++) exp_q.push_back(ent(i, rgb));
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_vsync();
    @(negedge clk) vsync = 1'b1;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_q_empty(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) @(negedge clk);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_n_req(input string tag, input int target, input int max_cyc);
    for (int i = 0; i < max_cyc && n_req < target; i++) @(negedge clk);
    check(tag, 32'(n_req >= target), 32'd1);
  endtask

  // After the last write: no capture until the second vsync rising edge.
  task automatic settle_and_check(input string tag);
    repeat (30) @(negedge clk);
    check({tag, "_pre_done"}, 32'(cfg_done), 32'd0);
    check({tag, "_pre_busy"}, 32'(busy), 32'd1);
    pulse_vsync();
    check({tag, "_cap_1st_vs"}, 32'(capture_en), 32'd0);
    pulse_vsync();
    check({tag, "_cap"}, 32'(capture_en), 32'd1);
    check({tag, "_done"}, 32'(cfg_done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  int base;

  initial begin
    rst = 1'b1; start = 1'b0; rgbmode = 1'b1; vsync = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(sccb.req), 32'd0);
    check("rst_addr", 32'(sccb.addr), 32'd0);
    check("rst_data", 32'(sccb.data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(cfg_done), 32'd0);
    check("rst_cap", 32'(capture_en), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Case 1: auto-configuration in RGB444 mode.
    push_run(1'b1, 0, 7);
    rst = 1'b0;
    @(negedge clk);
    check("busy_auto", 32'(busy), 32'd1);
    wait_q_empty("c1_writes", 2000);
    check("c1_n_req", 32'(n_req), 32'd8);
    if (req_cyc.size() >= 2)
      check("c1_rst_gap", 32'((req_cyc[1] - req_cyc[0]) >= 11), 32'd1);

    // Case 2: capture after the second vsync edge.
    settle_and_check("c2");
    check("c2_err", 32'(err), 32'd0);

    // Case 3: rgbmode change reruns with the YUV422 table.
    push_run(1'b0, 0, 7);
    @(negedge clk) rgbmode = 1'b0;
    @(negedge clk);
    check("c3_cap_drop", 32'(capture_en), 32'd0);
    check("c3_busy", 32'(busy), 32'd1);
    wait_q_empty("c3_writes", 2000);
    settle_and_check("c3");

    // Case 4: first request unanswered -> timeout, err, retry of the same entry.
    ignore_total = ignored + 1;
    exp_q.push_back(ent(0, 1'b0));
    push_run(1'b0, 0, 7);
    pulse_start();
    check("c4_err_clear", 32'(err), 32'd0);
    for (int i = 0; i < 60 && !err; i++) @(negedge clk);
    check("c4_err_set", 32'(err), 32'd1);
    wait_q_empty("c4_writes", 2000);
    settle_and_check("c4");
    check("c4_err_sticky", 32'(err), 32'd1);

    // Case 5: start during the idx-4 transfer; idx 4 completes, then restart.
    push_run(1'b0, 0, 4);
    push_run(1'b0, 0, 7);
    base = n_req;
    pulse_start();
    check("c5_err_by_start", 32'(err), 32'd0);
    check("c5_cap", 32'(capture_en), 32'd0);
    wait_n_req("c5_reach_idx4", base + 5, 1000);
    repeat (5) @(negedge clk);
    pulse_start();
    wait_q_empty("c5_writes", 3000);
    settle_and_check("c5");

    // Case 6: rst pulse during the post-soft-reset delay.
    exp_q.push_back(ent(0, 1'b0));
    base = n_req;
    pulse_start();
    wait_n_req("c6_first_req", base + 1, 100);
    repeat (25) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("c6_rst_req", 32'(sccb.req), 32'd0);
    check("c6_rst_busy", 32'(busy), 32'd0);
    check("c6_rst_done", 32'(cfg_done), 32'd0);
    check("c6_rst_cap", 32'(capture_en), 32'd0);
    check("c6_rst_err", 32'(err), 32'd0);
    check("c6_rst_addr", 32'(sccb.addr), 32'd0);
    push_run(1'b0, 0, 7);
    rst = 1'b0;
    wait_q_empty("c6_writes", 2000);
    settle_and_check("c6");
    check("c6_err", 32'(err), 32'd0);

    repeat (50) @(negedge clk);
    check("no_extra_req", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
